// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter owner and single-outstanding instruction fetcher
module fetch_pc_unit #(
    parameter int                PC_SRC_BITS_COUNT = 2,
    parameter int                XLEN              = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR      = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PC_SRC_BITS_COUNT-1:0] pc_source,
    input  logic [XLEN-1:0]              imm,
    input  logic [XLEN-1:0]              gpr_base,
    input  logic                         pc_update,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [XLEN-1:0]              imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [31:0]                  imem_rsp_data,
    output logic                         instr_valid,
    output logic [31:0]                  instr,
    output logic [XLEN-1:0]              pc,
    output logic                         misaligned
);

    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_4    = PC_SRC_BITS_COUNT'(0);
    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_PC_PLUS_IMM  = PC_SRC_BITS_COUNT'(1);
    localparam logic [PC_SRC_BITS_COUNT-1:0] PC_SRC_GPR_PLUS_IMM = PC_SRC_BITS_COUNT'(2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        TRAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_next;
    logic [31:0]       instr_next;
    logic              misaligned_next;

    // Indirect targets clear bit 0 so JALR-style jumps land on halfword boundaries at worst.
    always_comb begin
        target = pc + XLEN'(4);
        case (pc_source)
            PC_SRC_PC_PLUS_4:    target = pc + XLEN'(4);
            PC_SRC_PC_PLUS_IMM:  target = pc + imm;
            PC_SRC_GPR_PLUS_IMM: target = (gpr_base + imm) & ~XLEN'(1);
            default:             target = pc + XLEN'(4);
        endcase
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_next      = instr;
        misaligned_next = misaligned;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (imem_req_ready) state_next = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_next = imem_rsp_data;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (pc_update) begin
                    pc_next = target;
                    if (target[1:0] == 2'b00) begin
                        state_next = FETCH;
                    end else begin
                        misaligned_next = 1'b1;
                        state_next      = TRAP;
                    end
                end
            end
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            instr      <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr      <= instr_next;
            misaligned <= misaligned_next;
        end
    end

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign instr_valid    = (state == HOLD);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [1:0] SRC_PLUS_4   = 2'd0;
    localparam logic [1:0] SRC_PLUS_IMM = 2'd1;
    localparam logic [1:0] SRC_GPR_IMM  = 2'd2;
    localparam logic [1:0] SRC_ILLEGAL  = 2'd3;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_source = '0;
    logic [31:0] imm = '0;
    logic [31:0] gpr_base = '0;
    logic        pc_update = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;

    int total = 0;
    int passed = 0;

    fetch_pc_unit #(.PC_SRC_BITS_COUNT(2), .XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n), .pc_source(pc_source), .imm(imm), .gpr_base(gpr_base),
        .pc_update(pc_update), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] gpr;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] cur,
                                               input logic [31:0] im, input logic [31:0] gpr);
        case (src)
            SRC_PLUS_IMM: return cur + im;
            SRC_GPR_IMM:  return (gpr + im) & 32'hFFFF_FFFE;
            default:      return cur + 32'd4;
        endcase
    endfunction

    task automatic do_reset();
        int bad = 0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) bad++;
        end
        check("reset_outputs_low", 32'(bad), 32'd0);
        check("reset_pc", pc, RV);
        check("reset_misaligned", {31'd0, misaligned}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RV);
    endtask

    // Fetch one instruction; noise injects pc_update and dropped responses outside HOLD/WAIT.
    task automatic fetch(input logic [31:0] exp_addr, input int ready_delay, input logic [31:0] data,
                         input int rsp_delay, input bit same_cycle_rsp, input bit noise);
        int n = 0;
        int unstable = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("fetch_req_addr", imem_req_addr, exp_addr);
        for (int i = 0; i < ready_delay; i++) begin
            imem_req_ready = 1'b0;
            pc_update      = noise && $urandom_range(0, 1);
            pc_source      = 2'($urandom_range(0, 3));
            imm            = $urandom;
            imem_rsp_valid = noise && $urandom_range(0, 1);
            imem_rsp_data  = $urandom;
            @(negedge clk);
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) unstable++;
        end
        check("fetch_backpressure_stable", 32'(unstable), 32'd0);
        pc_update      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = same_cycle_rsp;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        check("wait_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
        check("wait_instr_valid_low", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < rsp_delay; i++) begin
            pc_update = noise;
            @(negedge clk);
        end
        pc_update      = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~data;
        check("hold_instr_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, data);
        check("hold_pc", pc, exp_addr);
        check("hold_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("hold_rsp_dropped", instr, data);
    endtask

    task automatic commit(input logic [1:0] src, input logic [31:0] im, input logic [31:0] gpr,
                          input logic [31:0] exp_pc);
        int bad = 0;
        pc_update = 1'b1;
        pc_source = src;
        imm       = im;
        gpr_base  = gpr;
        @(negedge clk);
        pc_update = 1'b0;
        if (exp_pc[1:0] == 2'b00) begin
            check("commit_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("commit_req_addr", imem_req_addr, exp_pc);
            check("commit_misaligned", {31'd0, misaligned}, 32'd0);
        end else begin
            check("trap_misaligned", {31'd0, misaligned}, 32'd1);
            check("trap_pc", pc, exp_pc);
            for (int i = 0; i < 10; i++) begin
                pc_update = 1'b1;
                imem_rsp_valid = 1'b1;
                @(negedge clk);
                if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1) bad++;
            end
            pc_update      = 1'b0;
            imem_rsp_valid = 1'b0;
            check("trap_stays_quiet", 32'(bad), 32'd0);
        end
    endtask

    vec_t vecs[$];
    logic [31:0] mpc;
    logic [31:0] nxt;
    logic [1:0]  src;
    logic [31:0] rimm;
    logic [31:0] rgpr;

    initial begin
        vecs.push_back('{SRC_PLUS_4,   32'h0000_0000, 32'h0000_0000, 32'h0000_0104});
        vecs.push_back('{SRC_PLUS_IMM, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_00FC});
        vecs.push_back('{SRC_GPR_IMM,  32'h0000_0003, 32'h0000_0201, 32'h0000_0204});
        vecs.push_back('{SRC_ILLEGAL,  32'h1234_5678, 32'h0000_0000, 32'h0000_0208});
        vecs.push_back('{SRC_PLUS_IMM, 32'hFFFF_FDF4, 32'h0000_0000, 32'hFFFF_FFFC});
        vecs.push_back('{SRC_PLUS_4,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{SRC_GPR_IMM,  32'h0000_0007, 32'h0000_0200, 32'h0000_0206});

        // reset, backpressure, then the directed target table ending in a misaligned trap
        do_reset();
        mpc = RV;
        fetch(mpc, 3, 32'h0000_0013, 0, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            commit(vecs[i].src, vecs[i].imm, vecs[i].gpr, vecs[i].exp_pc);
            mpc = vecs[i].exp_pc;
            if (mpc[1:0] == 2'b00)
                fetch(mpc, i % 2, 32'h1000_0000 + 32'(i), (i + 1) % 3, i == 1, 1'b0);
        end

        // best case plus same-cycle ready/response after trap recovery
        do_reset();
        fetch(RV, 0, 32'hCAFE_0001, 0, 1'b1, 1'b0);
        commit(SRC_PLUS_4, 32'h0, 32'h0, RV + 32'd4);

        // randomized traffic against the arithmetic model
        mpc = RV + 32'd4;
        fetch(mpc, 0, 32'hCAFE_0002, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            src  = 2'($urandom_range(0, 3));
            rimm = $urandom & 32'hFFFF_FFFC;
            rgpr = $urandom & 32'hFFFF_FFFD;
            nxt  = model_next(src, mpc, rimm, rgpr);
            commit(src, rimm, rgpr, nxt);
            mpc = nxt;
            fetch(mpc, $urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b1);
        end

        // async reset while a request is outstanding
        commit(SRC_PLUS_4, 32'h0, 32'h0, mpc + 32'd4);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2;
        rst_n     = 1'b0;
        pc_update = 1'b1;
        #1;
        check("midreset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midreset_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("midreset_pc", pc, RV);
        check("midreset_instr", instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pc_update = 1'b0;
        check("refetch_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("refetch_addr", imem_req_addr, RV);
        fetch(RV, 1, 32'h0000_0093, 1, 1'b0, 1'b0);

        // async reset while holding an instruction
        #2;
        rst_n = 1'b0;
        #1;
        check("holdreset_instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
